// File: rtl/riscv_fetch.sv
// Instruction fetch stage: owns the PC, drives a one-cycle-latency program
// memory, buffers returned words in a small FIFO and hands them to the
// decoder over valid/ready. A redirect flushes everything stale and restarts
// fetch at the new target.
module riscv_fetch #(
  parameter int unsigned          ILen      = 32,
  parameter int unsigned          AddrWidth = 16,
  parameter logic [AddrWidth-1:0] ResetPc   = '0,
  parameter int unsigned          FifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 pmem_req_o,
  output logic [AddrWidth-1:0] pmem_addr_o,
  input  logic [ILen-1:0]      pmem_rdata_i,
  input  logic                 redirect_i,
  input  logic [AddrWidth-1:0] redirect_pc_i,
  output logic                 instr_valid_o,
  output logic [ILen-1:0]      instr_o,
  output logic [AddrWidth-1:0] instr_pc_o,
  input  logic                 instr_ready_i
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  logic [AddrWidth-1:0] pc_q;
  logic                 inflight_q;
  logic [AddrWidth-1:0] inflight_pc_q;
  logic                 kill_q;

  logic [ILen-1:0]      data_q  [FifoDepth];
  logic [AddrWidth-1:0] ipc_q   [FifoDepth];
  logic [PtrW-1:0]      rd_ptr_q;
  logic [PtrW-1:0]      wr_ptr_q;
  logic [CntW-1:0]      count_q;

  logic                 pop;
  logic                 push;
  logic [CntW:0]        occupancy;
  logic [AddrWidth-1:0] redirect_target;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign instr_valid_o   = (count_q != '0);
  assign instr_o         = data_q[rd_ptr_q];
  assign instr_pc_o      = ipc_q[rd_ptr_q];
  assign pmem_addr_o     = pc_q;
  assign redirect_target = {redirect_pc_i[AddrWidth-1:2], 2'b00};

  assign pop  = instr_valid_o && instr_ready_i;
  // A response landing in a redirect cycle is dropped along with the flush.
  assign push = inflight_q && !kill_q && !redirect_i;

  // Issue credit: buffered plus in-flight, minus the entry leaving this cycle.
  always_comb begin
    occupancy  = {1'b0, count_q} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
    pmem_req_o = !rst_i && !redirect_i && (occupancy < (CntW + 1)'(FifoDepth));
  end

  // PC and in-flight request tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q          <= ResetPc;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      kill_q     <= redirect_i;
      inflight_q <= pmem_req_o;
      if (pmem_req_o) begin
        inflight_pc_q <= pc_q;
      end
      if (redirect_i) begin
        pc_q <= redirect_target;
      end else if (pmem_req_o) begin
        pc_q <= pc_q + AddrWidth'(4);
      end
    end
  end

  // Instruction buffer; a redirect empties it after any same-cycle transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        data_q[i] <= '0;
        ipc_q[i]  <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= pmem_rdata_i;
        ipc_q[wr_ptr_q]  <= inflight_pc_q;
        wr_ptr_q         <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// Randomized bench for riscv_fetch against a transaction-level model:
// expected delivered PC stream, outstanding-request budget and fill latency.
module tb_riscv_fetch;

  localparam int unsigned D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req2;
  logic [15:0] addr, addr2;
  logic [31:0] rdata, rdata2;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        valid, valid2;
  logic [31:0] instr, instr2;
  logic [15:0] instr_pc, instr_pc2;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_pc, fetch_pc, exp2_pc;
  int          held, since, since2;

  always #5 clk = ~clk;

  riscv_fetch #(.ILen(32), .AddrWidth(16), .ResetPc(16'h0000), .FifoDepth(D)) dut (
    .clk_i(clk), .rst_i(rst),
    .pmem_req_o(req), .pmem_addr_o(addr), .pmem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_ready_i(ready)
  );

  riscv_fetch #(.ILen(32), .AddrWidth(16), .ResetPc(16'hFFF8), .FifoDepth(D)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .pmem_req_o(req2), .pmem_addr_o(addr2), .pmem_rdata_i(rdata2),
    .redirect_i(1'b0), .redirect_pc_i(16'h0000),
    .instr_valid_o(valid2), .instr_o(instr2), .instr_pc_o(instr_pc2),
    .instr_ready_i(1'b1)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'h0000_0013 + (32'(a >> 2) << 7);
  endfunction

  // Synchronous program memories; unrequested cycles return junk.
  always @(posedge clk) begin
    rdata  <= req  ? mem_word(addr)  : $urandom;
    rdata2 <= req2 ? mem_word(addr2) : $urandom;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic reset_model();
    exp_pc   = 16'h0000;
    fetch_pc = 16'h0000;
    exp2_pc  = 16'hFFF8;
    held     = 0;
    since    = 0;
    since2   = 0;
  endtask

  // One clock cycle: drive inputs just after the edge, check at the falling edge.
  task automatic cycle(input bit rdy, input bit rd, input logic [15:0] tgt);
    bit pop, exp_req;
    ready       = rdy;
    redirect    = rd;
    redirect_pc = tgt;
    @(negedge clk);
    check("valid", {31'b0, valid}, {31'b0, since >= 2});
    if (since >= 2) begin
      check("instr_pc", {16'b0, instr_pc}, {16'b0, exp_pc});
      check("instr", instr, mem_word(exp_pc));
    end
    pop     = (since >= 2) && rdy;
    exp_req = !rd && ((held - int'(pop)) < int'(D));
    check("pmem_req", {31'b0, req}, {31'b0, exp_req});
    if (exp_req) check("pmem_addr", {16'b0, addr}, {16'b0, fetch_pc});
    check("valid2", {31'b0, valid2}, {31'b0, since2 >= 2});
    if (since2 >= 2) begin
      check("instr_pc2", {16'b0, instr_pc2}, {16'b0, exp2_pc});
      check("instr2", instr2, mem_word(exp2_pc));
    end
    if (pop) begin
      exp_pc = exp_pc + 16'd4;
      held--;
    end
    if (rd) begin
      exp_pc   = {tgt[15:2], 2'b00};
      fetch_pc = exp_pc;
      held     = 0;
      since    = 0;
    end else begin
      if (exp_req) begin
        fetch_pc = fetch_pc + 16'd4;
        held++;
      end
      if (since < 2) since++;
    end
    if (since2 >= 2) exp2_pc = exp2_pc + 16'd4;
    if (since2 < 2) since2++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    ready       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", {16'b0, instr_pc}, 32'd0);
    check("rst_valid2", {31'b0, valid2}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();

    repeat (20) cycle(1'b1, 1'b0, 16'h0);
    repeat (12) cycle(1'b0, 1'b0, 16'h0);
    repeat (6)  cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h0103);
    repeat (8)  cycle(1'b1, 1'b0, 16'h0);
    repeat (400) cycle(($urandom % 10) < 7, ($urandom % 16) == 0, 16'($urandom));
    repeat (6)  cycle(1'b0, 1'b0, 16'h0);

    // Asynchronous reset mid-cycle with the buffer full.
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, valid}, 32'd0);
    check("mid_rst_req", {31'b0, req}, 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    check("mid_rst_valid2", {31'b0, valid2}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    repeat (12) cycle(1'b1, 1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
